// File: rtl/mult_repeated_add_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
//   state_e       : control FSM states with a fixed 2-bit encoding
//   WIDTH_DEFAULT : default operand/result width
package mult_repeated_add_pkg;

   localparam int unsigned WIDTH_DEFAULT = 16;
   localparam int unsigned STATE_W       = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : mult_repeated_add_pkg

// File: rtl/mult_datapath.sv
// Datapath for the repeated-addition multiplier: operand/count registers,
// accumulator, adder, decrementer and the count==0 detect.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_en_i  : capture operands, clear accumulator
//   calc_en_i  : one add step (acc += A, B -= 1)
//   a_i, b_i   : operands
//   acc_o      : accumulator register (the product when finished)
//   b_zero_c   : combinational flag, remaining count is zero
module mult_datapath
   import mult_repeated_add_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en_i,
   input  logic             calc_en_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             b_zero_c
);

   logic [WIDTH-1:0] reg_a_q, reg_a_d;
   logic [WIDTH-1:0] reg_b_q, reg_b_d;
   logic [WIDTH-1:0] acc_q,   acc_d;

   // Next-state: load has priority; the add wraps modulo 2^WIDTH.
   always_comb begin
      reg_a_d = reg_a_q;
      reg_b_d = reg_b_q;
      acc_d   = acc_q;
      if (load_en_i) begin
         reg_a_d = a_i;
         reg_b_d = b_i;
         acc_d   = '0;
      end else if (calc_en_i) begin
         acc_d   = WIDTH'(acc_q + reg_a_q);
         reg_b_d = WIDTH'(reg_b_q - WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_a_q <= '0;
         reg_b_q <= '0;
         acc_q   <= '0;
      end else begin
         reg_a_q <= reg_a_d;
         reg_b_q <= reg_b_d;
         acc_q   <= acc_d;
      end
   end

   assign acc_o    = acc_q;
   assign b_zero_c = (reg_b_q == '0);

endmodule : mult_datapath

// File: rtl/mult_repeated_add.sv
// Unsigned multiplier computing A*B by adding A into an accumulator B times.
//   clk               : rising-edge clock
//   reset             : asynchronous active-low reset
//   input_available   : operands valid, sampled in IDLE only
//   operands_bits_A/B : multiplicand / repeat count
//   result_bits_data  : accumulator, A*B mod 2^WIDTH once finished
//   result_rdy        : product valid (DONE state)
//   result_taken      : consumer accepts product, sampled in DONE only
module mult_repeated_add
   import mult_repeated_add_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             input_available,
   input  logic [WIDTH-1:0] operands_bits_A,
   input  logic [WIDTH-1:0] operands_bits_B,
   output logic [WIDTH-1:0] result_bits_data,
   output logic             result_rdy,
   input  logic             result_taken
);

   state_e state_q, state_d;
   logic   load_en;
   logic   calc_en;
   logic   b_zero;

   mult_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk       (clk),
      .rst_n     (reset),
      .load_en_i (load_en),
      .calc_en_i (calc_en),
      .a_i       (operands_bits_A),
      .b_i       (operands_bits_B),
      .acc_o     (result_bits_data),
      .b_zero_c  (b_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode; the illegal encoding recovers to IDLE.
   always_comb begin
      state_d    = state_q;
      load_en    = 1'b0;
      calc_en    = 1'b0;
      result_rdy = 1'b0;
      case (state_q)
         IDLE: begin
            if (input_available) begin
               load_en = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (b_zero) begin
               state_d = DONE;
            end else begin
               calc_en = 1'b1;
            end
         end
         DONE: begin
            result_rdy = 1'b1;
            if (result_taken) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : mult_repeated_add

// File: tb/tb_mult_repeated_add.sv
// Self-checking bench for mult_repeated_add against an arithmetic model.
module tb_mult_repeated_add;

   localparam int unsigned W = 16;

   logic         clk;
   logic         reset;
   logic         input_available;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] result_bits_data;
   logic         result_rdy;
   logic         result_taken;

   int n_tests;
   int n_fail;

   mult_repeated_add #(.WIDTH(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .input_available  (input_available),
      .operands_bits_A  (op_a),
      .operands_bits_B  (op_b),
      .result_bits_data (result_bits_data),
      .result_rdy       (result_rdy),
      .result_taken     (result_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      return W'(p % 65536);
   endfunction

   function automatic int model_latency(input logic [W-1:0] b);
      return int'(b) + 2;
   endfunction

   // Stimulus only: accept operands, then count edges until result_rdy (bounded).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, output int lat);
      @(negedge clk);
      op_a = a; op_b = b; input_available = 1'b1;
      @(posedge clk); #1;
      input_available = 1'b0;
      lat = 1;
      while (!result_rdy && lat < int'(b) + 10) begin
         if (disturb) begin
            op_a = W'($urandom);
            op_b = W'($urandom);
            input_available = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         lat++;
      end
      input_available = 1'b0;
      if (!result_rdy) lat = -1;
   endtask

   task automatic take_result();
      @(negedge clk);
      result_taken = 1'b1;
      @(posedge clk); #1;
      result_taken = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; input_available = 1'b0; result_taken = 1'b0;
      op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (result_rdy !== 1'b0) begin
         n_fail++; $display("FAIL reset_rdy got %0b want 0", result_rdy);
      end
      n_tests++;
      if (result_bits_data !== 16'd0) begin
         n_fail++; $display("FAIL reset_data got %0d want 0", result_bits_data);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (result_rdy !== 1'b0) begin
         n_fail++; $display("FAIL idle_rdy got %0b want 0", result_rdy);
      end
   endtask

   task automatic test_directed();
      int lat;
      logic [W-1:0] a_tab [4] = '{16'd8, 16'd5, 16'd0, 16'd300};
      logic [W-1:0] b_tab [4] = '{16'd7, 16'd0, 16'd5, 16'd300};
      for (int i = 0; i < 4; i++) begin
         run_op(a_tab[i], b_tab[i], 1'b0, lat);
         n_tests++;
         if (lat !== model_latency(b_tab[i])) begin
            n_fail++;
            $display("FAIL dir%0d_latency got %0d want %0d", i, lat, model_latency(b_tab[i]));
         end
         n_tests++;
         if (result_bits_data !== model_product(a_tab[i], b_tab[i])) begin
            n_fail++;
            $display("FAIL dir%0d_product got %0d want %0d", i, result_bits_data,
                     model_product(a_tab[i], b_tab[i]));
         end
         take_result();
         n_tests++;
         if (result_rdy !== 1'b0) begin
            n_fail++; $display("FAIL dir%0d_take got rdy %0b want 0", i, result_rdy);
         end
      end
   endtask

   task automatic test_hold();
      int lat;
      run_op(16'd8, 16'd7, 1'b0, lat);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if (result_rdy !== 1'b1 || result_bits_data !== 16'd56) begin
            n_fail++;
            $display("FAIL hold_c%0d got rdy %0b data %0d want 1/56", c, result_rdy, result_bits_data);
         end
      end
      take_result();
      n_tests++;
      if (result_rdy !== 1'b0 || result_bits_data !== 16'd56) begin
         n_fail++;
         $display("FAIL hold_release got rdy %0b data %0d want 0/56", result_rdy, result_bits_data);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      @(negedge clk);
      op_a = 16'd3; op_b = 16'd10; input_available = 1'b1;
      @(posedge clk); #1;
      input_available = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if (result_bits_data !== 16'd12) begin
         n_fail++; $display("FAIL midcalc_partial got %0d want 12", result_bits_data);
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if (result_bits_data !== 16'd0 || result_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL midcalc_async got data %0d rdy %0b want 0/0", result_bits_data, result_rdy);
      end
      @(negedge clk); reset = 1'b1;
      run_op(16'd2, 16'd3, 1'b0, lat);
      n_tests++;
      if (lat !== 5 || result_bits_data !== 16'd6) begin
         n_fail++;
         $display("FAIL after_reset got lat %0d data %0d want 5/6", lat, result_bits_data);
      end
      take_result();
   endtask

   task automatic test_disturb();
      int lat;
      logic [W-1:0] a, b;
      for (int i = 0; i < 4; i++) begin
         a = W'($urandom);
         b = W'($urandom_range(1, 30));
         run_op(a, b, 1'b1, lat);
         n_tests++;
         if (lat !== model_latency(b) || result_bits_data !== model_product(a, b)) begin
            n_fail++;
            $display("FAIL disturb%0d got lat %0d data %0d want %0d/%0d", i, lat,
                     result_bits_data, model_latency(b), model_product(a, b));
         end
         take_result();
      end
   endtask

   task automatic test_random();
      int lat;
      logic [W-1:0] a, b;
      for (int i = 0; i < 12; i++) begin
         a = W'($urandom);
         b = W'($urandom_range(0, 60));
         run_op(a, b, 1'b0, lat);
         n_tests++;
         if (lat !== model_latency(b)) begin
            n_fail++;
            $display("FAIL rand%0d_latency got %0d want %0d", i, lat, model_latency(b));
         end
         n_tests++;
         if (result_bits_data !== model_product(a, b)) begin
            n_fail++;
            $display("FAIL rand%0d_product a=%0d b=%0d got %0d want %0d", i, a, b,
                     result_bits_data, model_product(a, b));
         end
         take_result();
      end
   endtask

   // Accept and take asserted together in DONE: IDLE first, accept one edge later.
   task automatic test_back_to_back();
      int lat;
      logic [W-1:0] prev;
      run_op(16'd9, 16'd4, 1'b0, lat);
      prev = model_product(16'd9, 16'd4);
      @(negedge clk);
      op_a = 16'd11; op_b = 16'd6;
      input_available = 1'b1; result_taken = 1'b1;
      @(posedge clk); #1;
      result_taken = 1'b0;
      n_tests++;
      if (result_rdy !== 1'b0 || result_bits_data !== prev) begin
         n_fail++;
         $display("FAIL b2b_idle got rdy %0b data %0d want 0/%0d", result_rdy, result_bits_data, prev);
      end
      @(posedge clk); #1;
      input_available = 1'b0;
      n_tests++;
      if (result_bits_data !== 16'd0) begin
         n_fail++; $display("FAIL b2b_accept_clear got %0d want 0", result_bits_data);
      end
      lat = 1;
      while (!result_rdy && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      n_tests++;
      if (lat !== model_latency(16'd6) || result_bits_data !== model_product(16'd11, 16'd6)) begin
         n_fail++;
         $display("FAIL b2b_second got lat %0d data %0d want %0d/%0d", lat, result_bits_data,
                  model_latency(16'd6), model_product(16'd11, 16'd6));
      end
      take_result();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid_calc();
      test_disturb();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mult_repeated_add
